alarm_sched: RTL and testbench
==============================

Name: alarm_sched

Overview:
Alarm sequencing controller for the alarm clock. It watches the current-time and alarm-time registers of the time datapath and decides when Buzz rings. It gates ringing by weekday, runs the snooze and ring-timeout timers, and cancels the alarm when the user edits time or alarm. It sits between the time/alarm counters and the Buzz output of top_level.

Parameters:
SNOOZE_MIN, 9, snooze length in minutes (legal range 1..15).
RING_MAX_MIN, 5, auto-off after this many minutes of continuous ringing (legal range 1..15).
WEEKEND_MASK, 7'b1100000, bit d=1 suppresses the alarm on day d (0=Mon .. 6=Sun); the default suppresses Sat and Sun.

Ports:
Clk  in  1  system clock; the single clock domain.
Reset  in  1  synchronous, active-high reset.
Tick  in  1  one-Clk-wide strobe, once per simulated second.
Alarmon  in  1  alarm enable switch (level).
Timeset  in  1  time-edit mode (level).
Alarmset  in  1  alarm-edit mode (level).
Snooze  in  1  snooze button (level; rising edge is detected internally).
Cur_hrs  in  5  current hour, 0..23.
Cur_min  in  6  current minute, 0..59.
Cur_sec  in  6  current second, 0..59.
Cur_day  in  3  current day, 0..6 (0=Mon).
Alm_hrs  in  5  alarm hour, 0..23.
Alm_min  in  6  alarm minute, 0..59.
Buzz  out  1  buzzer drive.
State  out  2  FSM state: 0=IDLE, 1=RING, 2=SNOOZE.
Snooze_sec  out  10  seconds of snooze remaining; 0 outside SNOOZE.

Behaviour:
- Clocking and reset:
  - All flops are on posedge Clk.
  - Reset is synchronous, active-high, and dominates every other input.
  - On reset: State=IDLE, Buzz=0, Snooze_sec=0, ring counter=0, snooze_q=1, match_q=1.
  - Because match_q resets to 1, a time that already equals the alarm at reset release does not ring.
- Match condition (combinational):
  - match = Alarmon & ~Timeset & ~Alarmset & (Cur_hrs==Alm_hrs) & (Cur_min==Alm_min) & (Cur_sec==0) & day_ok.
  - day_ok = (Cur_day<=6) & ~WEEKEND_MASK[Cur_day]. Cur_day=7 means day_ok=0.
  - match_q is registered every cycle.
  - trig = match & ~match_q, i.e. a rising edge of match.
- Snooze edge: snooze_q is registered every cycle; snz = Snooze & ~snooze_q.
- Cancel condition: cancel = ~Alarmon | Timeset | Alarmset.
- IDLE:
  - On trig, go to RING and clear the ring counter.
  - Buzz goes to 1 on the Clk edge after the cycle in which trig is true (latency 1 cycle).
- RING (Buzz=1):
  - Priority: cancel, then snz, then timeout.
  - cancel: go to IDLE.
  - snz: go to SNOOZE and load Snooze_sec = SNOOZE_MIN*60.
  - Otherwise, on each Tick the ring counter increments. When it reaches RING_MAX_MIN*60, go to IDLE.
  - A snz in the same cycle as the timeout Tick wins and enters SNOOZE.
- SNOOZE (Buzz=0):
  - cancel: go to IDLE and clear Snooze_sec.
  - Otherwise, each Tick decrements Snooze_sec.
  - A Tick that takes Snooze_sec from 1 to 0 sends the FSM to RING and clears the ring counter.
  - snz and trig are ignored in SNOOZE.
- Buzz and State are registered outputs that decode the state register. No combinational path runs from inputs to outputs.
- Retrigger: trig can only fire again after match drops. Cur_sec leaves 0 one second later, so the auto-off in the same minute never retriggers. The next ring is the following matching day.
- Widths: Snooze_sec and the ring counter are 10 bits (max 15*60 = 900). Comparisons are unsigned; wrap-around cannot occur within the legal parameter range.
- Reset mid-RING or mid-SNOOZE returns to IDLE with Buzz=0 on the next edge.

Decomposition:
- Package alarm_pkg holds:
  - typedef enum logic [1:0] {IDLE, RING, SNOOZE} alarm_state_t;
  - TICKS_PER_MIN = 60;
  - day constants MON=0 .. SUN=6.
- One sub-module, sec_timer: a 10-bit Tick-driven counter with load, clear, and done flag. It is instanced twice: the ring timer counts up, the snooze timer counts down with the Snooze_sec output.

Test Plan:
1. Alarm 08:01, day=4 (Fri), Alarmon=1; advance time 08:00:59 -> 08:01:00 -> Buzz=1 one Clk after the match cycle, State=1.
2. Same alarm, day=5 (Sat) and day=6 (Sun) -> Buzz stays 0. Day=0 (Mon) -> rings.
3. While ringing, pulse Snooze -> State=2, Buzz=0, Snooze_sec=540. After 540 Ticks -> Buzz=1 again with the ring counter restarted.
4. Ring with no input: after 300 Ticks -> Buzz=0, State=0, no retrigger during 08:06.
5. While ringing, assert Alarmset, or Timeset, or drop Alarmon (each case separately) -> IDLE within 1 Clk. Repeat the same check from SNOOZE.
6. Reset with time=alarm=00:00:00, day 0, Alarmon=1 -> Buzz stays 0 after reset release. Also assert Reset during RING -> Buzz=0 next edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencing controller.
// Holds the FSM state encoding, timer width and weekday constants.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  localparam int TICKS_PER_MIN = 60;
  localparam int CNT_W         = 10;

  localparam logic [2:0] MON = 3'd0;
  localparam logic [2:0] TUE = 3'd1;
  localparam logic [2:0] WED = 3'd2;
  localparam logic [2:0] THU = 3'd3;
  localparam logic [2:0] FRI = 3'd4;
  localparam logic [2:0] SAT = 3'd5;
  localparam logic [2:0] SUN = 3'd6;

  function automatic logic [CNT_W-1:0] min_to_sec(input int m);
    return CNT_W'(m * TICKS_PER_MIN);
  endfunction

endpackage

// File: rtl/alarm_sched_sec_timer.sv
// sec_timer: 10-bit Tick-driven seconds counter with clear, load and
// done flag. Ports: clk_i, rst_i (sync, high), tick_i, en_i, clr_i,
// load_i, load_val_i -> cnt_o, done_o (this Tick reaches TARGET).
module sec_timer
  import alarm_pkg::*;
#(
  parameter bit               COUNT_UP = 1'b1,
  parameter logic [CNT_W-1:0] TARGET   = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_step;
  logic             step;

  assign step     = tick_i & en_i;
  assign cnt_step = COUNT_UP ? cnt_q + 1'b1 : cnt_q - 1'b1;

  // Done flags the Tick that lands on TARGET, so the owner can change
  // state on the same edge the count gets there.
  assign done_o = step & (cnt_step == TARGET);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (step) begin
      cnt_d = cnt_step;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_sched.sv
// alarm_sched: decides when Buzz rings from current/alarm time, with
// weekday gating, snooze and ring auto-off. Inputs: Clk, Reset, Tick,
// Alarmon, Timeset, Alarmset, Snooze, Cur_*, Alm_*.
// Outputs: Buzz, State (0 idle/1 ring/2 snooze), Snooze_sec.
module alarm_sched
  import alarm_pkg::*;
#(
  parameter int         SNOOZE_MIN   = 9,
  parameter int         RING_MAX_MIN = 5,
  parameter logic [6:0] WEEKEND_MASK = 7'b1100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Alarmon,
  input  logic       Timeset,
  input  logic       Alarmset,
  input  logic       Snooze,
  input  logic [4:0] Cur_hrs,
  input  logic [5:0] Cur_min,
  input  logic [5:0] Cur_sec,
  input  logic [2:0] Cur_day,
  input  logic [4:0] Alm_hrs,
  input  logic [5:0] Alm_min,
  output logic       Buzz,
  output logic [1:0] State,
  output logic [9:0] Snooze_sec
);

  localparam logic [CNT_W-1:0] SNZ_LEN  = min_to_sec(SNOOZE_MIN);
  localparam logic [CNT_W-1:0] RING_LEN = min_to_sec(RING_MAX_MIN);

  alarm_state_t state_q, state_d;
  logic         buzz_q;
  logic         match_q, snooze_q;

  logic match, trig, snz, cancel, day_ok;
  logic [7:0] day_sup;

  logic ring_en, ring_clr, ring_done;
  logic snz_en, snz_load, snz_clr, snz_done;
  logic [CNT_W-1:0] ring_cnt;
  logic [CNT_W-1:0] snz_cnt;

  // Day 7 is not a real day; the extra top bit suppresses it.
  assign day_sup = {1'b1, WEEKEND_MASK};
  assign day_ok  = ~day_sup[Cur_day];

  assign cancel = ~Alarmon | Timeset | Alarmset;

  assign match = ~cancel
               & (Cur_hrs == Alm_hrs)
               & (Cur_min == Alm_min)
               & (Cur_sec == 6'd0)
               & day_ok;

  assign trig = match & ~match_q;
  assign snz  = Snooze & ~snooze_q;

  // Timer enables are kept outside the FSM block so the done flags
  // never loop back through the next-state logic.
  assign ring_en = (state_q == RING) & ~cancel & ~snz;
  assign snz_en  = (state_q == SNOOZE) & ~cancel;

  sec_timer #(
    .COUNT_UP (1'b1),
    .TARGET   (RING_LEN)
  ) u_ring_tmr (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .tick_i     (Tick),
    .en_i       (ring_en),
    .clr_i      (ring_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (ring_cnt),
    .done_o     (ring_done)
  );

  sec_timer #(
    .COUNT_UP (1'b0),
    .TARGET   ('0)
  ) u_snz_tmr (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .tick_i     (Tick),
    .en_i       (snz_en),
    .clr_i      (snz_clr),
    .load_i     (snz_load),
    .load_val_i (SNZ_LEN),
    .cnt_o      (snz_cnt),
    .done_o     (snz_done)
  );

  always_comb begin
    state_d  = state_q;
    ring_clr = 1'b0;
    snz_load = 1'b0;
    snz_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d  = RING;
          ring_clr = 1'b1;
        end
      end
      RING: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (snz) begin
          state_d  = SNOOZE;
          snz_load = 1'b1;
        end else if (ring_done) begin
          state_d = IDLE;
        end
      end
      SNOOZE: begin
        if (cancel) begin
          state_d = IDLE;
          snz_clr = 1'b1;
        end else if (snz_done) begin
          state_d  = RING;
          ring_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        snz_clr = 1'b1;
      end
    endcase
  end

  // Edge detectors reset high so a level already present at reset
  // release is not mistaken for a fresh edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      buzz_q   <= 1'b0;
      match_q  <= 1'b1;
      snooze_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      buzz_q   <= (state_d == RING);
      match_q  <= match;
      snooze_q <= Snooze;
    end
  end

  assign Buzz       = buzz_q;
  assign State      = state_q;
  assign Snooze_sec = snz_cnt;

  logic unused_ok;
  assign unused_ok = ^ring_cnt;

endmodule

// File: tb/tb_alarm_sched.sv
// Testbench for alarm_sched: directed scenarios plus randomized phase,
// checked each cycle against a behavioural model of the alarm rules.
module tb_alarm_sched;

  localparam int SNZ_SEC  = 9 * 60;
  localparam int RING_SEC = 5 * 60;
  localparam logic [6:0] WMASK = 7'b1100000;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Tick = 1'b0;
  logic       Alarmon = 1'b1;
  logic       Timeset = 1'b0;
  logic       Alarmset = 1'b0;
  logic       Snooze = 1'b0;
  logic [4:0] Cur_hrs = '0;
  logic [5:0] Cur_min = '0;
  logic [5:0] Cur_sec = '0;
  logic [2:0] Cur_day = '0;
  logic [4:0] Alm_hrs = '0;
  logic [5:0] Alm_min = '0;
  logic       Buzz;
  logic [1:0] State;
  logic [9:0] Snooze_sec;

  alarm_sched dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Tick       (Tick),
    .Alarmon    (Alarmon),
    .Timeset    (Timeset),
    .Alarmset   (Alarmset),
    .Snooze     (Snooze),
    .Cur_hrs    (Cur_hrs),
    .Cur_min    (Cur_min),
    .Cur_sec    (Cur_sec),
    .Cur_day    (Cur_day),
    .Alm_hrs    (Alm_hrs),
    .Alm_min    (Alm_min),
    .Buzz       (Buzz),
    .State      (State),
    .Snooze_sec (Snooze_sec)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: mode 0 idle, 1 ringing, 2 snoozing.
  int m_mode = 0;
  int m_snz = 0;
  int m_rung = 0;
  bit m_mprev = 1'b1;
  bit m_sprev = 1'b1;
  bit m_init = 1'b0;

  function automatic bit alarm_hit();
    bit ok_day;
    ok_day = (Cur_day <= 3'd6) && !WMASK[Cur_day];
    return Alarmon && !Timeset && !Alarmset && ok_day &&
           (Cur_hrs == Alm_hrs) && (Cur_min == Alm_min) &&
           (Cur_sec == 6'd0);
  endfunction

  always @(posedge Clk) begin
    bit hit, cxl, first, press;
    hit   = alarm_hit();
    cxl   = !Alarmon || Timeset || Alarmset;
    first = hit && !m_mprev;
    press = Snooze && !m_sprev;
    if (Reset) begin
      m_mode = 0; m_snz = 0; m_rung = 0;
      m_mprev = 1'b1; m_sprev = 1'b1;
      m_init = 1'b1;
    end else begin
      if (m_mode == 0) begin
        if (first) begin m_mode = 1; m_rung = 0; end
      end else if (m_mode == 1) begin
        if (cxl) m_mode = 0;
        else if (press) begin m_mode = 2; m_snz = SNZ_SEC; end
        else if (Tick) begin
          m_rung = m_rung + 1;
          if (m_rung >= RING_SEC) m_mode = 0;
        end
      end else begin
        if (cxl) begin m_mode = 0; m_snz = 0; end
        else if (Tick) begin
          m_snz = m_snz - 1;
          if (m_snz == 0) begin m_mode = 1; m_rung = 0; end
        end
      end
      m_mprev = hit;
      m_sprev = Snooze;
    end
  end

  int    lit_seq = 0;
  int    lit_seen = 0;
  string lit_name;
  bit    lit_buzz;
  int    lit_state;
  int    lit_sec;

  always @(negedge Clk) begin
    if (m_init) begin
      n_chk++;
      if (Buzz !== (m_mode == 1) || State !== 2'(m_mode) ||
          Snooze_sec !== 10'(m_snz)) begin
        n_fail++;
        $display("FAIL model t=%0t buzz=%b state=%0d sec=%0d want %0d/%0d/%0d",
                 $time, Buzz, State, Snooze_sec,
                 (m_mode == 1), m_mode, m_snz);
      end
    end
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      n_chk++;
      if (Buzz !== lit_buzz || State !== 2'(lit_state) ||
          Snooze_sec !== 10'(lit_sec)) begin
        n_fail++;
        $display("FAIL %s buzz=%b state=%0d sec=%0d want %b/%0d/%0d",
                 lit_name, Buzz, State, Snooze_sec,
                 lit_buzz, lit_state, lit_sec);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic expect_lit(input string nm, input bit b,
                            input int st, input int sec);
    lit_name  = nm;
    lit_buzz  = b;
    lit_state = st;
    lit_sec   = sec;
    lit_seq++;
    #5;
  endtask

  task automatic adv_time();
    if (Cur_sec == 6'd59) begin
      Cur_sec = 0;
      if (Cur_min == 6'd59) begin
        Cur_min = 0;
        if (Cur_hrs == 5'd23) begin
          Cur_hrs = 0;
          Cur_day = (Cur_day >= 3'd6) ? 3'd0 : Cur_day + 3'd1;
        end else Cur_hrs = Cur_hrs + 5'd1;
      end else Cur_min = Cur_min + 6'd1;
    end else Cur_sec = Cur_sec + 6'd1;
  endtask

  task automatic tick_sec();
    Tick = 1'b1;
    cyc(1);
    Tick = 1'b0;
    adv_time();
    cyc(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_sec();
  endtask

  task automatic set_time(input int h, input int m, input int s,
                          input int d);
    Cur_hrs = 5'(h);
    Cur_min = 6'(m);
    Cur_sec = 6'(s);
    Cur_day = 3'(d);
  endtask

  task automatic start_ring(input int d);
    set_time(8, 0, 59, d);
    cyc(1);
    tick_sec();
  endtask

  task automatic press_snooze();
    Snooze = 1'b1;
    cyc(1);
    Snooze = 1'b0;
  endtask

  task automatic apply_cancel(input int k, input bit on);
    if (k == 0) Alarmset = on;
    else if (k == 1) Timeset = on;
    else Alarmon = !on;
  endtask

  initial begin
    Alm_hrs = 5'd0;
    Alm_min = 6'd0;
    set_time(0, 0, 0, 0);
    Reset = 1'b1;
    cyc(3);
    Reset = 1'b0;
    cyc(3);
    expect_lit("reset_match_no_ring", 1'b0, 0, 0);

    Alm_hrs = 5'd8;
    Alm_min = 6'd1;
    start_ring(4);
    expect_lit("fri_ring", 1'b1, 1, 0);
    press_snooze();
    expect_lit("snooze_load", 1'b0, 2, SNZ_SEC);
    ticks(SNZ_SEC - 1);
    expect_lit("snooze_last", 1'b0, 2, 1);
    tick_sec();
    expect_lit("snooze_rering", 1'b1, 1, 0);
    ticks(RING_SEC - 1);
    expect_lit("ring_before_timeout", 1'b1, 1, 0);
    tick_sec();
    expect_lit("ring_timeout", 1'b0, 0, 0);

    start_ring(5);
    cyc(2);
    expect_lit("sat_quiet", 1'b0, 0, 0);
    start_ring(6);
    cyc(2);
    expect_lit("sun_quiet", 1'b0, 0, 0);
    start_ring(7);
    cyc(2);
    expect_lit("day7_quiet", 1'b0, 0, 0);
    start_ring(0);
    expect_lit("mon_ring", 1'b1, 1, 0);
    ticks(RING_SEC);
    expect_lit("mon_timeout", 1'b0, 0, 0);
    ticks(60);
    expect_lit("no_retrigger", 1'b0, 0, 0);

    for (int k = 0; k < 3; k++) begin
      start_ring(4);
      expect_lit("cancel_ring_pre", 1'b1, 1, 0);
      apply_cancel(k, 1'b1);
      cyc(1);
      expect_lit("cancel_ring", 1'b0, 0, 0);
      tick_sec();
      apply_cancel(k, 1'b0);
      cyc(1);
    end
    for (int k = 0; k < 3; k++) begin
      start_ring(4);
      press_snooze();
      ticks(3);
      expect_lit("snooze_run", 1'b0, 2, SNZ_SEC - 3);
      apply_cancel(k, 1'b1);
      cyc(1);
      expect_lit("cancel_snooze", 1'b0, 0, 0);
      tick_sec();
      apply_cancel(k, 1'b0);
      cyc(1);
    end

    start_ring(1);
    Reset = 1'b1;
    cyc(1);
    expect_lit("reset_in_ring", 1'b0, 0, 0);
    Reset = 1'b0;
    cyc(3);
    expect_lit("after_reset_quiet", 1'b0, 0, 0);

    set_time(8, 0, 50, 2);
    for (int i = 0; i < 4000; i++) begin
      Snooze   = ($urandom_range(0, 5) == 0);
      Alarmon  = ($urandom_range(0, 59) != 0);
      Timeset  = ($urandom_range(0, 89) == 0);
      Alarmset = ($urandom_range(0, 89) == 0);
      Reset    = ($urandom_range(0, 499) == 0);
      if (Cur_min >= 6'd3 || $urandom_range(0, 299) == 0)
        set_time(8, 0, $urandom_range(50, 59), $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) tick_sec();
      else cyc(1);
    end
    Reset = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
